axi_map_loader: RTL

//  DRAM-to-SRAM frame loader for the routing engine. On a start pulse it issues one
//  AXI4 INCR read burst of 128 beats x 128 bits (2 KB) that fetches a 64x64 4-bit map.

---
 rtl/axi_map_loader.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/axi_map_loader.sv
// Loads one 64x64 4-bit routing map (128 x 128-bit beats) from DRAM over a single
// AXI4 INCR read burst and writes each beat into the local map SRAM at its beat index.
module axi_map_loader #(
    parameter int          ID_WIDTH      = 4,
    parameter int          DATA_WIDTH    = 128,
    parameter int          ADDR_WIDTH    = 32,
    parameter logic [31:0] FRAME_OFFSET  = 32'h0001_0000,
    parameter logic [31:0] WEIGHT_OFFSET = 32'h0002_0000,
    parameter logic [31:0] FRAME_SHIFT   = 32'h0000_0800,
    parameter int          AXI_ID        = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4:0]            frame_id,
    input  logic                  map_sel,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            state_dbg,
    output logic [ID_WIDTH-1:0]   arid_m_inf,
    output logic [ADDR_WIDTH-1:0] araddr_m_inf,
    output logic [7:0]            arlen_m_inf,
    output logic [2:0]            arsize_m_inf,
    output logic [1:0]            arburst_m_inf,
    output logic                  arvalid_m_inf,
    input  logic                  arready_m_inf,
    input  logic [ID_WIDTH-1:0]   rid_m_inf,
    input  logic [DATA_WIDTH-1:0] rdata_m_inf,
    input  logic [1:0]            rresp_m_inf,
    input  logic                  rlast_m_inf,
    input  logic                  rvalid_m_inf,
    output logic                  rready_m_inf,
    output logic                  mem_we,
    output logic [6:0]            mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_AR   = 2'd1;
    localparam logic [1:0] S_R    = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // arvalid/araddr are held until arready, rready is high for the whole R phase.

    logic [1:0]            state_q, state_d;
    logic [6:0]            beat_q, beat_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic                  err_q, err_d;
    logic                  mem_we_q, mem_we_d;
    logic [6:0]            mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  beat_bad;

    // Any protocol violation on an accepted beat marks the whole load as erroneous.
    assign beat_bad = (rresp_m_inf != 2'b00)
                   || (rid_m_inf != ID_WIDTH'(AXI_ID))
                   || (rlast_m_inf && (beat_q != 7'd127))
                   || (!rlast_m_inf && (beat_q == 7'd127));

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        araddr_d    = araddr_q;
        err_d       = err_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_AR;
                    err_d    = 1'b0;
                    araddr_d = (map_sel ? ADDR_WIDTH'(WEIGHT_OFFSET) : ADDR_WIDTH'(FRAME_OFFSET))
                             + ADDR_WIDTH'(frame_id) * ADDR_WIDTH'(FRAME_SHIFT);
                end
            end
            S_AR: begin
                if (arready_m_inf) begin
                    state_d = S_R;
                    beat_d  = 7'd0;
                end
            end
            S_R: begin
                if (rvalid_m_inf) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = beat_q;
                    mem_wdata_d = rdata_m_inf;
                    beat_d      = beat_q + 7'd1;
                    if (beat_bad) begin
                        err_d = 1'b1;
                    end
                    if (rlast_m_inf) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            beat_q      <= 7'd0;
            araddr_q    <= '0;
            err_q       <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 7'd0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            araddr_q    <= araddr_d;
            err_q       <= err_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign err           = err_q;
    assign state_dbg     = state_q;
    assign arid_m_inf    = ID_WIDTH'(AXI_ID);
    assign araddr_m_inf  = araddr_q;
    assign arlen_m_inf   = 8'd127;
    assign arsize_m_inf  = 3'b100;
    assign arburst_m_inf = 2'b01;
    assign arvalid_m_inf = (state_q == S_AR);
    assign rready_m_inf  = (state_q == S_R);
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;

endmodule
